counter_seq_ctrl: RTL and testbench
===================================

Name: counter_seq_ctrl

Overview:
Sequencer for the 4-bit ripple `counter` block (ports q, cout, reset, cin, clk). It owns the counter's reset and cin inputs and watches its q and cout. It runs the counter for a programmed number of counts, made of whole 16-count wraps plus a residual q value. The cin rate is set by a prescaler, and the block supports one-shot or periodic (auto-restart) operation.

Parameters:
PRESCALE_W, 8, width of prescale input; cin may be asserted at most once every prescale+1 clk cycles.
WRAP_W, 4, width of the wrap counter and the tgt_wraps input.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
start  input  1  level; sampled in IDLE or DONE to launch a run.
stop  input  1  level; aborts any activity and returns to IDLE.
periodic  input  1  latched at start; 1 = auto-restart on match, 0 = one-shot.
prescale  input  PRESCALE_W  latched at start; number of idle cycles between cin pulses.
tgt_wraps  input  WRAP_W  latched at start; number of cout wraps required.
tgt_q  input  4  latched at start; q value required after the wraps.
cnt_q  input  4  counter q.
cnt_cout  input  1  counter carry-out.
cnt_reset  output  1  active-high clear to the counter.
cnt_cin  output  1  count enable to the counter.
busy  output  1  high in CLEAR and RUN.
done  output  1  level; high in DONE.
tick  output  1  one-cycle pulse on every match (both modes).

Behaviour:
- States: IDLE, CLEAR, RUN, DONE. Registered 2-bit encoding.
- Reset asserted: state=IDLE, pre_cnt=0, wrap_cnt=0, latched config=0, tick=0. While reset is low, cnt_reset=1 and cnt_cin=0.
- IDLE: cnt_reset=0, cnt_cin=0. On start & !stop: latch periodic, prescale, tgt_wraps and tgt_q, then go to CLEAR.
- CLEAR (exactly 1 cycle): cnt_reset=1, pre_cnt<=0, wrap_cnt<=0, then go to RUN.
- RUN:
  - pre_tick = (pre_cnt == prescale_l).
  - pre_cnt wraps to 0 on pre_tick, otherwise increments.
  - match = (wrap_cnt == tgt_wraps_l) && (cnt_q == tgt_q_l).
  - cnt_cin = pre_tick && !match. This is combinational, so the counter never overshoots, even with prescale=0.
  - wrap_cnt increments on each edge where cnt_cin && cnt_cout. It saturates at its maximum value and never wraps.
- On match in RUN:
  - tick=1 for that cycle.
  - periodic_l=1: next state is CLEAR; restart costs 2 cycles including the match cycle.
  - periodic_l=0: next state is DONE.
- DONE: cnt_cin=0, counter holds its value, done=1. start & !stop re-latches config and goes to CLEAR.
- stop has priority over every other event. On the next edge the state becomes IDLE with cnt_cin=0; the counter is not cleared (q is preserved for debug).
- start while in CLEAR or RUN is ignored; config changes mid-run are ignored.
- Total cin pulses per run = tgt_wraps*16 + tgt_q. Target 0/0 matches in the first RUN cycle with zero cin pulses.
- Cycles from start to match ≈ 2 + (prescale+1)*(16*tgt_wraps + tgt_q).
- Reset asserted mid-run: immediate IDLE; cnt_reset is forced high asynchronously.

Decomposition:
- Shared package `counter_pkg`: state enum (IDLE, CLEAR, RUN, DONE), CNT_W=4, CNT_MAX=4'hF.
- One natural sub-module, `prescaler`: the pre_cnt/pre_tick generator, with clk, reset, clr, en, and prescale inputs and a tick output.
- Everything else is a flat FSM. The bench instantiates `counter` alongside this block.

Test Plan:
- One-shot, prescale=0, tgt_wraps=0, tgt_q=5, start pulse → exactly 5 cin cycles, q=5, done=1, tick once, busy falls after 7 cycles.
- One-shot, prescale=3, tgt_wraps=2, tgt_q=3 → 35 cin pulses each spaced 4 cycles apart, 2 cout wraps counted, final q=3, done=1.
- Periodic, prescale=1, tgt_wraps=0, tgt_q=4 → tick every 10 cycles (2 CLEAR/restart + 4 pulses × 2), three consecutive ticks, cnt_reset high for 1 cycle between runs.
- stop asserted mid-run at q=7, start also high on the same edge → IDLE next cycle, cnt_cin=0, q stays 7, done=0.
- reset driven low during RUN → busy/done/tick=0 and cnt_reset=1 immediately. After release, state is IDLE; the next start runs the full count from 0.
- Target 0/0 → tick in the first RUN cycle, zero cin pulses, done=1.

Source files
------------

// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg : shared types and constants for the counter sequencer slice
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

    localparam int              CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/prescaler.sv
// ---------------------------------------------------------------------------
// prescaler : divides clk down to one tick every prescale+1 enabled cycles
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] pre_cnt_q;
    logic [PRESCALE_W-1:0] pre_cnt_d;

    assign tick_o = en_i && (pre_cnt_q == prescale_i);

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (clr_i) begin
            pre_cnt_d = '0;
        end else if (en_i) begin
            pre_cnt_d = tick_o ? '0 : pre_cnt_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// counter_seq_ctrl : runs a 4-bit counter for tgt_wraps*16 + tgt_q counts
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module counter_seq_ctrl
    import counter_pkg::*;
#(
    parameter int PRESCALE_W = 8,
    parameter int WRAP_W     = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  periodic_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic [WRAP_W-1:0]     tgt_wraps_i,
    input  logic [CNT_W-1:0]      tgt_q_i,
    input  logic [CNT_W-1:0]      cnt_q_i,
    input  logic                  cnt_cout_i,
    output logic                  cnt_reset_o,
    output logic                  cnt_cin_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  tick_o
);

    localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

    state_e                state_q;
    logic                  cfg_periodic_q;
    logic [PRESCALE_W-1:0] cfg_prescale_q;
    logic [WRAP_W-1:0]     cfg_wraps_q;
    logic [CNT_W-1:0]      cfg_tgt_q;
    logic [WRAP_W-1:0]     wrap_cnt_q;

    logic in_run;
    logic pre_tick;
    logic match;

    assign in_run = (state_q == RUN);
    assign match  = (wrap_cnt_q == cfg_wraps_q) && (cnt_q_i == cfg_tgt_q);

    prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (state_q == CLEAR),
        .en_i       (in_run),
        .prescale_i (cfg_prescale_q),
        .tick_o     (pre_tick)
    );

    // cin is gated by match in the same cycle so the counter cannot overshoot
    assign cnt_cin_o   = in_run && pre_tick && !match && !stop_i;
    assign tick_o      = in_run && match && !stop_i;
    assign cnt_reset_o = !rst_ni || (state_q == CLEAR);
    assign busy_o      = (state_q == CLEAR) || in_run;
    assign done_o      = (state_q == DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            cfg_periodic_q <= 1'b0;
            cfg_prescale_q <= '0;
            cfg_wraps_q    <= '0;
            cfg_tgt_q      <= '0;
            wrap_cnt_q     <= '0;
        end else if (stop_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        cfg_periodic_q <= periodic_i;
                        cfg_prescale_q <= prescale_i;
                        cfg_wraps_q    <= tgt_wraps_i;
                        cfg_tgt_q      <= tgt_q_i;
                        state_q        <= CLEAR;
                    end
                end
                CLEAR: begin
                    wrap_cnt_q <= '0;
                    state_q    <= RUN;
                end
                RUN: begin
                    if (match) begin
                        state_q <= cfg_periodic_q ? CLEAR : DONE;
                    end else if (cnt_cin_o && cnt_cout_i && (wrap_cnt_q != WRAP_MAX)) begin
                        wrap_cnt_q <= wrap_cnt_q + WRAP_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_seq_ctrl : scoreboard bench for counter_seq_ctrl with a 4-bit counter model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_counter_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       periodic;
    logic [7:0] prescale;
    logic [3:0] tgt_wraps;
    logic [3:0] tgt_q;
    logic [3:0] cnt_q;
    logic       cnt_cout;
    logic       cnt_reset;
    logic       cnt_cin;
    logic       busy;
    logic       done;
    logic       tick;

    typedef struct {
        int q;
        int pulses;
        int cycles;
    } exp_t;

    exp_t sb[$];

    int n_chk      = 0;
    int n_fail     = 0;
    int run_cyc    = 0;
    int pulses     = 0;
    int last_cin   = -1;
    int gap_err    = 0;
    int wraps_seen = 0;
    int ticks_seen = 0;

    counter_seq_ctrl #(
        .PRESCALE_W (8),
        .WRAP_W     (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .stop_i      (stop),
        .periodic_i  (periodic),
        .prescale_i  (prescale),
        .tgt_wraps_i (tgt_wraps),
        .tgt_q_i     (tgt_q),
        .cnt_q_i     (cnt_q),
        .cnt_cout_i  (cnt_cout),
        .cnt_reset_o (cnt_reset),
        .cnt_cin_o   (cnt_cin),
        .busy_o      (busy),
        .done_o      (done),
        .tick_o      (tick)
    );

    // Behavioural model of the 4-bit counter being sequenced
    always_ff @(posedge clk) begin
        if (cnt_reset) begin
            cnt_q <= 4'd0;
        end else if (cnt_cin) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end
    assign cnt_cout = cnt_cin & (&cnt_q);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: run bookkeeping plus scoreboard pop on every tick
    always @(negedge clk) begin
        if (!rst_n) begin
            run_cyc  = 0;
            pulses   = 0;
            last_cin = -1;
        end else begin
            if (busy && cnt_reset) begin
                run_cyc  = 1;
                pulses   = 0;
                last_cin = -1;
            end else begin
                run_cyc++;
            end
            if (tick) begin
                ticks_seen++;
                check("sb_has_entry_at_tick", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("tick_q", int'(cnt_q), e.q);
                    check("tick_pulses", pulses, e.pulses);
                    check("tick_cycles", run_cyc, e.cycles);
                end
            end
            if (cnt_cin) begin
                if (last_cin >= 0 && (run_cyc - last_cin) != int'(prescale) + 1) gap_err++;
                last_cin = run_cyc;
                pulses++;
                if (cnt_cout) wraps_seen++;
            end
        end
    end

    task automatic config_run(input logic per, input int p, input int w, input int q);
        periodic  = per;
        prescale  = 8'(p);
        tgt_wraps = 4'(w);
        tgt_q     = 4'(q);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(done), 1);
    endtask

    task automatic wait_q(input string name, input int val, input int bound);
        int n = 0;
        while (int'(cnt_q) != val && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(cnt_q), val);
    endtask

    initial begin
        int busy_cyc;
        int n;
        exp_t e;

        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        config_run(1'b0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_cnt_reset", int'(cnt_reset), 1);
        check("rst_cnt_cin", int'(cnt_cin), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_tick", int'(tick), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cnt_reset", int'(cnt_reset), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_q", int'(cnt_q), 0);

        // One-shot, prescale 0, 5 counts
        config_run(1'b0, 0, 0, 5);
        e = '{q: 5, pulses: 5, cycles: 7};
        sb.push_back(e);
        start_pulse();
        busy_cyc = 0;
        n = 0;
        while (busy && n < 50) begin
            busy_cyc++;
            n++;
            @(negedge clk);
        end
        check("t1_busy_cycles", busy_cyc, 7);
        check("t1_done", int'(done), 1);
        check("t1_q", int'(cnt_q), 5);
        check("t1_ticks", ticks_seen, 1);

        // One-shot with wraps: 35 pulses spaced 4 cycles
        config_run(1'b0, 3, 2, 3);
        gap_err    = 0;
        wraps_seen = 0;
        e = '{q: 3, pulses: 35, cycles: 142};
        sb.push_back(e);
        start_pulse();
        wait_done("t2_done", 400);
        check("t2_q", int'(cnt_q), 3);
        check("t2_wraps", wraps_seen, 2);
        check("t2_gap_err", gap_err, 0);
        check("t2_sb_empty", sb.size(), 0);

        // Periodic: three ticks, 10 cycles apart
        config_run(1'b1, 1, 0, 4);
        for (int i = 0; i < 3; i++) begin
            e = '{q: 4, pulses: 4, cycles: 10};
            sb.push_back(e);
        end
        ticks_seen = 0;
        start_pulse();
        n = 0;
        while (ticks_seen < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t3_ticks", ticks_seen, 3);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t3_stop_busy", int'(busy), 0);
        check("t3_sb_empty", sb.size(), 0);

        // Stop at q=7 with start also high
        config_run(1'b0, 0, 1, 0);
        start_pulse();
        wait_q("t4_reach_q7", 7, 40);
        stop  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("t4_busy", int'(busy), 0);
        check("t4_done", int'(done), 0);
        check("t4_cin", int'(cnt_cin), 0);
        check("t4_q", int'(cnt_q), 7);
        stop  = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_q_hold", int'(cnt_q), 7);
        check("t4_idle", int'(busy), 0);

        // Asynchronous reset mid-run, then a full rerun
        config_run(1'b0, 0, 0, 9);
        start_pulse();
        wait_q("t5_reach_q3", 3, 40);
        rst_n = 1'b0;
        #1;
        check("t5_busy", int'(busy), 0);
        check("t5_done", int'(done), 0);
        check("t5_tick", int'(tick), 0);
        check("t5_cnt_reset", int'(cnt_reset), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_post_busy", int'(busy), 0);
        check("t5_post_done", int'(done), 0);
        e = '{q: 9, pulses: 9, cycles: 11};
        sb.push_back(e);
        start_pulse();
        wait_done("t5_rerun_done", 60);
        check("t5_rerun_q", int'(cnt_q), 9);

        // Target 0/0 matches in the first RUN cycle
        config_run(1'b0, 5, 0, 0);
        e = '{q: 0, pulses: 0, cycles: 2};
        sb.push_back(e);
        start_pulse();
        wait_done("t6_done", 20);
        check("t6_q", int'(cnt_q), 0);
        check("t6_sb_empty", sb.size(), 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
